gearbox_stream_arbiter: RTL

Round-robin AXI-Stream arbiter that shares one `gearbox_downsizing_2x` instance between N upstream requesters. It locks the grant to one requester for a whole packet, delimited by `tlast`. It drives the gearbox input through a one-deep registered output stage and tags each beat with the source index. It sits directly in front of the gearbox input port; `m_*` connects to the gearbox `in_*`.

---
 rtl/gearbox_stream_arbiter.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/gearbox_stream_arbiter.sv
// -----------------------------------------------------------------------------
// gearbox_stream_arbiter
//
// Round-robin AXI-Stream arbiter sharing one gearbox_downsizing_2x between N
// requesters. The grant is locked to one requester for a whole packet
// (delimited by tlast). The selected beat passes through a one-deep registered
// output stage and is tagged with the source index on m_tid.
//
// Optional feature: define GEARBOX_ARB_BURST_LIMIT_EN to release the grant
// after MAX_BURST beats even when tlast has not been seen. The packet then
// resumes at that requester's next grant, so downstream must use m_tid to
// reassemble it.
// -----------------------------------------------------------------------------
module gearbox_stream_arbiter #(
    parameter int unsigned N         = 4,
    parameter int unsigned W         = 80,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [N*W-1:0]       s_tdata,
    input  logic [N-1:0]         s_tvalid,
    input  logic [N-1:0]         s_tlast,
    output logic [N-1:0]         s_tready,
    output logic [W-1:0]         m_tdata,
    output logic                 m_tvalid,
    output logic                 m_tlast,
    output logic [$clog2(N)-1:0] m_tid,
    input  logic                 m_tready,
    output logic                 busy
);

    localparam int unsigned IW = $clog2(N);

    // Reject configurations outside the supported range at elaboration time.
    if (N < 2 || N > 8) begin : g_chk_n
        $error("gearbox_stream_arbiter: N must be in 2..8");
    end
    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_chk_burst
        $error("gearbox_stream_arbiter: MAX_BURST must be in 1..255");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Arbitration state
    state_t          state_q, state_d;
    logic [IW-1:0]   grant_q, grant_d;
    logic [IW-1:0]   last_grant_q, last_grant_d;

    // Output stage registers
    logic [W-1:0]    m_tdata_q, m_tdata_d;
    logic            m_tvalid_q, m_tvalid_d;
    logic            m_tlast_q, m_tlast_d;
    logic [IW-1:0]   m_tid_q, m_tid_d;

    // Combinational helpers
    logic            pick_valid;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   cand;
    logic [W-1:0]    sel_data;
    logic            sel_valid;
    logic            sel_last;
    logic            out_free;
    logic            accept;
    logic            burst_hit;

    // The output register can take a new beat when empty or being drained
    // on the same edge, which keeps a packet at one beat per cycle.
    assign out_free = !m_tvalid_q || m_tready;
    assign accept   = (state_q == GRANT) && sel_valid && out_free;

    // Cyclic search for the first requesting input after last_grant.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int k = 1; k <= int'(N); k++) begin
            cand = IW'((int'(last_grant_q) + k) % int'(N));
            if (!pick_valid && s_tvalid[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Route the granted requester's data, valid and last to the output stage.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (grant_q == IW'(i)) begin
                sel_data  = s_tdata[i*W +: W];
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
            end
        end
    end

    // Ready goes only to the granted requester, and only while the output
    // stage can take a beat; it is zero in IDLE.
    always_comb begin
        s_tready = '0;
        if (state_q == GRANT) begin
            for (int i = 0; i < int'(N); i++) begin
                if (grant_q == IW'(i)) begin
                    s_tready[i] = out_free;
                end
            end
        end
    end

`ifdef GEARBOX_ARB_BURST_LIMIT_EN
    logic [7:0] beat_cnt_q, beat_cnt_d;

    // The accept that brings the count up to MAX_BURST ends the grant.
    assign burst_hit = accept && (({1'b0, beat_cnt_q} + 9'd1) == 9'(MAX_BURST));

    // Beat counter: cleared when a new grant is taken, bumped on each accept.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (state_q == IDLE && pick_valid) begin
            beat_cnt_d = '0;
        end else if (accept) begin
            beat_cnt_d = beat_cnt_q + 8'd1;
        end
    end

    // Beat counter register.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end
`else
    // Without the limit the grant is held until tlast.
    assign burst_hit = 1'b0;
`endif

    // Next-state logic: take a grant in IDLE, release it on a tlast (or
    // burst-limit) accept. A granted requester that drops valid keeps the
    // grant; there is deliberately no timeout.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (accept && (sel_last || burst_hit)) begin
                    last_grant_d = grant_q;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output stage: load on accept, otherwise drop valid once the gearbox
    // has taken the held beat. Payload holds while valid is stalled.
    always_comb begin
        m_tdata_d  = m_tdata_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        m_tid_d    = m_tid_q;
        if (accept) begin
            m_tdata_d  = sel_data;
            m_tvalid_d = 1'b1;
            m_tlast_d  = sel_last;
            m_tid_d    = grant_q;
        end else if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
        end
    end

    // Arbitration state registers. Reset sets last_grant to N-1 so that
    // requester 0 wins the first arbitration.
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the values from before the edge, whatever the block order.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(N - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // Output stage registers; reset discards any held beat immediately.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            m_tid_q    <= '0;
        end else begin
            m_tdata_q  <= m_tdata_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            m_tid_q    <= m_tid_d;
        end
    end

    assign m_tdata  = m_tdata_q;
    assign m_tvalid = m_tvalid_q;
    assign m_tlast  = m_tlast_q;
    assign m_tid    = m_tid_q;
    assign busy     = (state_q == GRANT);

endmodule
